gobang_axil_regs: RTL and testbench
===================================

// Module: gobang_axil_regs
// PURPOSE
// AXI4-Lite responder (slave) fronting the gobang IP: four 32-bit RW control/data registers at offsets 0x0/0x4/0x8/0xC.
// Answers the write/read bursts the master VIP issues in the bfm_design bench.
// Presents register contents and per-register write pulses to the gobang core logic.
// One outstanding write and one outstanding read; all responses are OKAY.
// PARAMETERS
// DATA_WIDTH  32  AXI data width; only 32 is supported.
// ADDR_WIDTH  4   AXI address width; bits [3:2] select the register, higher bits are ignored.
// NUM_REGS    4   register count; fixed at 4.
// PORTS
// ACLK           in   1     clock; all logic is rising-edge.
// ARESETN        in   1     asynchronous active-low reset.
// S_AXI_AWADDR   in   AW    write address.
// S_AXI_AWPROT   in   3     ignored.
// S_AXI_AWVALID  in   1     / S_AXI_AWREADY out 1: AW handshake.
// S_AXI_WDATA    in   32    write data.
// S_AXI_WSTRB    in   4     byte enables.
// S_AXI_WVALID   in   1     / S_AXI_WREADY out 1: W handshake.
// S_AXI_BRESP    out  2     always 2'b00.
// S_AXI_BVALID   out  1     / S_AXI_BREADY in 1: B handshake.
// S_AXI_ARADDR   in   AW    read address.
// S_AXI_ARPROT   in   3     ignored.
// S_AXI_ARVALID  in   1     / S_AXI_ARREADY out 1: AR handshake.
// S_AXI_RDATA    out  32    read data.
// S_AXI_RRESP    out  2     always 2'b00.
// S_AXI_RVALID   out  1     / S_AXI_RREADY in 1: R handshake.
// reg_q          out  4x32  current register values.
// reg_wr_pulse   out  4     one-cycle pulse on the cycle after a register is committed.
// BEHAVIOUR
// - Reset (async assert, sync release): all regs 0, all VALID/READY low, reg_wr_pulse 0, RDATA 0.
//   Reset mid-transaction drops it; no B/R response is issued.
// - Write path: AW and W are latched independently, in either order or in the same cycle.
//   AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
// - Commit: in the cycle where aw_held && w_held (counting same-cycle handshakes), bytes with WSTRB=1 are updated.
//   WSTRB=0 bytes are kept; WSTRB=4'h0 still produces a B response and a pulse.
//   BVALID rises on the next edge and holds until BREADY; the held flags clear at commit.
// - Write latency: AW+W in cycle N -> BVALID at N+1. A new AW/W is accepted only after the B handshake.
// - Read path: ARREADY = !RVALID. On AR handshake, RDATA = reg[ARADDR[3:2]] and RVALID rises the next cycle.
//   RDATA stays stable until RREADY.
// - Read latency: 1 cycle. Back-to-back reads run at 1 per 2 cycles.
// - Same-cycle read and write commit to one register: the read returns the pre-write value.
// - Unaligned address: bits [1:0] are ignored.
// - States: write FSM W_IDLE -> (W_HAVE_AW | W_HAVE_W) -> W_RESP -> W_IDLE.
//   W_IDLE may jump directly to W_RESP when AW and W arrive together. Read FSM R_IDLE <-> R_RESP.
// STRUCTURE
// - gobang_regs_pkg holds: REG_CTRL=2'd0, REG_MOVE=2'd1, REG_STAT=2'd2, REG_AUX=2'd3, RESP_OKAY=2'b00, and the write/read state enums.
// - Single module, no sub-modules. Byte-strobe merge is a function in gobang_regs_pkg.
// TESTING
// - Write 1,2,3,4 to 0x0/0x4/0x8/0xC, then read back -> RDATA 1,2,3,4; RRESP=0, BRESP=0.
// - W issued 3 cycles before AW, and AW before W -> reg updates once; BVALID 1 cycle after the later handshake; one pulse.
// - Write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB=4'b0101 -> reg1 reads 0xAA22CC44.
// - BREADY held low 5 cycles -> BVALID held, AWREADY/WREADY low, a second AW is stalled.
//   RVALID behaves the same while RREADY is held low.
// - AR 0x8 in the same cycle as the commit of a write 0x55 to 0x8 (old value 3) -> RDATA 3; a later read returns 0x55.
// - ARESETN pulsed low while BVALID is pending -> BVALID 0 immediately, regs 0; a fresh write then completes normally.

Source files
------------

// File: rtl/gobang_regs_pkg.sv
// Shared register indices, response codes, bus FSM states and the byte-strobe merge
// for the gobang AXI4-Lite register block.
package gobang_regs_pkg;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_MOVE  = 2'd1;
   localparam logic [1:0] REG_STAT  = 2'd2;
   localparam logic [1:0] REG_AUX   = 2'd3;
   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_RESP} rstate_e;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/gobang_axil_regs_if.sv
// AXI4-Lite bus bundle between the bench/VIP master and the gobang register slave.
interface gobang_axil_regs_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]              S_AXI_AWPROT;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]              S_AXI_ARPROT;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/gobang_axil_regs.sv
// AXI4-Lite slave with four 32-bit RW registers feeding the gobang core,
// one outstanding write and one outstanding read, all responses OKAY.
module gobang_axil_regs
   import gobang_regs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 4
) (
   input  logic                                 ACLK,
   input  logic                                 ARESETN,
   gobang_axil_regs_if.slave                    s_axi,
   output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_q,
   output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

   wstate_e                             wstate_q, wstate_d;
   rstate_e                             rstate_q, rstate_d;
   logic                                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic                                arready_q, arready_d, rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
   logic [1:0]                          waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]               wdata_q, wdata_d;
   logic [3:0]                          wstrb_q, wstrb_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_d;
   logic [NUM_REGS-1:0]                 pulse_q, pulse_d;

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [1:0]            cidx;
   logic [DATA_WIDTH-1:0] cdata;
   logic [3:0]            cstrb;
   logic                  unused_ok;

   assign aw_hs = s_axi.S_AXI_AWVALID && awready_q;
   assign w_hs  = s_axi.S_AXI_WVALID  && wready_q;
   assign ar_hs = s_axi.S_AXI_ARVALID && arready_q;
   assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   always_comb begin
      wstate_d = wstate_q;
      rstate_d = rstate_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      reg_d    = reg_q;
      pulse_d  = '0;
      commit   = 1'b0;
      cidx     = waddr_q;
      cdata    = wdata_q;
      cstrb    = wstrb_q;

      if (aw_hs) waddr_d = s_axi.S_AXI_AWADDR[3:2];
      if (w_hs) begin
         wdata_d = s_axi.S_AXI_WDATA;
         wstrb_d = s_axi.S_AXI_WSTRB;
      end

      // Whichever half arrives last is taken straight from the bus so the
      // commit happens in the handshake cycle itself.
      unique case (wstate_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               cidx   = s_axi.S_AXI_AWADDR[3:2];
               cdata  = s_axi.S_AXI_WDATA;
               cstrb  = s_axi.S_AXI_WSTRB;
            end else if (aw_hs) wstate_d = W_HAVE_AW;
            else if (w_hs)      wstate_d = W_HAVE_W;
         end
         W_HAVE_AW: if (w_hs) begin
            commit = 1'b1;
            cdata  = s_axi.S_AXI_WDATA;
            cstrb  = s_axi.S_AXI_WSTRB;
         end
         W_HAVE_W: if (aw_hs) begin
            commit = 1'b1;
            cidx   = s_axi.S_AXI_AWADDR[3:2];
         end
         W_RESP: if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase

      if (commit) begin
         wstate_d      = W_RESP;
         reg_d[cidx]   = strb_merge(reg_q[cidx], cdata, cstrb);
         pulse_d[cidx] = 1'b1;
      end

      // Read samples reg_q, so a same-cycle commit is not visible yet.
      unique case (rstate_q)
         R_IDLE: if (ar_hs) begin
            rdata_d  = reg_q[s_axi.S_AXI_ARADDR[3:2]];
            rstate_d = R_RESP;
         end
         R_RESP: if (s_axi.S_AXI_RREADY) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase

      bvalid_d  = (wstate_d == W_RESP);
      awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
      wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
      rvalid_d  = (rstate_d == R_RESP);
      arready_d = (rstate_d == R_IDLE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wstate_q  <= W_IDLE;
         rstate_q  <= R_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         reg_q     <= '0;
         pulse_q   <= '0;
      end else begin
         wstate_q  <= wstate_d;
         rstate_q  <= rstate_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         reg_q     <= reg_d;
         pulse_q   <= pulse_d;
      end
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = RESP_OKAY;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = RESP_OKAY;
   assign reg_wr_pulse        = pulse_q;

endmodule

// File: tb/tb_gobang_axil_regs.sv
// Bench for gobang_axil_regs: directed bus scenarios plus randomized traffic
// checked against an array model of the four registers.
module tb_gobang_axil_regs;
   import gobang_regs_pkg::*;

   localparam int TMO = 50;

   logic            ACLK, ARESETN;
   logic [3:0][31:0] reg_q;
   logic [3:0]       reg_wr_pulse;
   logic [31:0]      mdl [4];
   int               n_chk, n_fail;

   gobang_axil_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

   gobang_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(axi),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic mdl_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
      for (int b = 0; b < 4; b++)
         if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
   endtask

   // Called at a negedge; returns at the negedge following the B handshake.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit probe_aw);
      int idx;
      bit aw_seen, w_seen;
      idx = int'(addr[3:2]);
      aw_seen = 1'b0;
      w_seen  = 1'b0;
      fork
         begin
            int t = 0;
            repeat (aw_dly) @(negedge ACLK);
            axi.S_AXI_AWADDR  = addr;
            axi.S_AXI_AWVALID = 1'b1;
            while (!axi.S_AXI_AWREADY && t < TMO) begin @(negedge ACLK); t++; end
            if (t >= TMO) chk("aw_timeout", 0, 1);
            aw_seen = 1'b1;
            @(negedge ACLK);
            axi.S_AXI_AWVALID = 1'b0;
            if (!w_seen) chk("bvalid_before_w", 32'(axi.S_AXI_BVALID), 0);
         end
         begin
            int t = 0;
            repeat (w_dly) @(negedge ACLK);
            axi.S_AXI_WDATA  = data;
            axi.S_AXI_WSTRB  = strb;
            axi.S_AXI_WVALID = 1'b1;
            while (!axi.S_AXI_WREADY && t < TMO) begin @(negedge ACLK); t++; end
            if (t >= TMO) chk("w_timeout", 0, 1);
            w_seen = 1'b1;
            @(negedge ACLK);
            axi.S_AXI_WVALID = 1'b0;
            if (!aw_seen) chk("bvalid_before_aw", 32'(axi.S_AXI_BVALID), 0);
         end
      join
      mdl_write(idx, data, strb);
      chk("bvalid_rise", 32'(axi.S_AXI_BVALID), 1);
      chk("bresp", 32'(axi.S_AXI_BRESP), 0);
      chk("wr_pulse", 32'(reg_wr_pulse), 32'(1) << idx);
      chk("reg_after_wr", reg_q[idx], mdl[idx]);
      if (probe_aw) begin
         axi.S_AXI_AWADDR  = 4'h0;
         axi.S_AXI_AWVALID = 1'b1;
      end
      for (int i = 0; i < b_dly; i++) begin
         @(negedge ACLK);
         chk("bvalid_hold", 32'(axi.S_AXI_BVALID), 1);
         chk("awready_stall", 32'(axi.S_AXI_AWREADY), 0);
         chk("wready_stall", 32'(axi.S_AXI_WREADY), 0);
         if (i == 0) chk("wr_pulse_once", 32'(reg_wr_pulse), 0);
      end
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_BREADY  = 1'b1;
      @(negedge ACLK);
      axi.S_AXI_BREADY = 1'b0;
      chk("bvalid_drop", 32'(axi.S_AXI_BVALID), 0);
      if (b_dly == 0) chk("wr_pulse_once", 32'(reg_wr_pulse), 0);
   endtask

   task automatic axi_read(input logic [3:0] addr, input int r_dly);
      int t = 0;
      int idx;
      logic [31:0] exp;
      idx = int'(addr[3:2]);
      axi.S_AXI_ARADDR  = addr;
      axi.S_AXI_ARVALID = 1'b1;
      while (!axi.S_AXI_ARREADY && t < TMO) begin @(negedge ACLK); t++; end
      if (t >= TMO) chk("ar_timeout", 0, 1);
      exp = mdl[idx];
      @(negedge ACLK);
      axi.S_AXI_ARVALID = 1'b0;
      chk("rvalid_rise", 32'(axi.S_AXI_RVALID), 1);
      chk("rdata", axi.S_AXI_RDATA, exp);
      chk("rresp", 32'(axi.S_AXI_RRESP), 0);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge ACLK);
         chk("rvalid_hold", 32'(axi.S_AXI_RVALID), 1);
         chk("rdata_hold", axi.S_AXI_RDATA, exp);
         chk("arready_stall", 32'(axi.S_AXI_ARREADY), 0);
      end
      axi.S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      axi.S_AXI_RREADY = 1'b0;
      chk("rvalid_drop", 32'(axi.S_AXI_RVALID), 0);
   endtask

   task automatic chk_all_regs(input string tag);
      for (int i = 0; i < 4; i++) chk(tag, reg_q[i], mdl[i]);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      ARESETN           = 1'b0;
      axi.S_AXI_AWADDR  = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WDATA   = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY  = 1'b0;
      axi.S_AXI_ARADDR  = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY  = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("rst_awready", 32'(axi.S_AXI_AWREADY), 0);
      chk("rst_wready", 32'(axi.S_AXI_WREADY), 0);
      chk("rst_arready", 32'(axi.S_AXI_ARREADY), 0);
      chk("rst_bvalid", 32'(axi.S_AXI_BVALID), 0);
      chk("rst_rvalid", 32'(axi.S_AXI_RVALID), 0);
      chk("rst_rdata", axi.S_AXI_RDATA, 0);
      chk("rst_pulse", 32'(reg_wr_pulse), 0);
      chk_all_regs("rst_reg");
      ARESETN = 1'b1;
      @(negedge ACLK);

      // Basic write/readback over the register map
      axi_write({REG_CTRL, 2'b00}, 32'd1, 4'hF, 0, 0, 0, 1'b0);
      axi_write({REG_MOVE, 2'b00}, 32'd2, 4'hF, 0, 0, 1, 1'b0);
      axi_write({REG_STAT, 2'b00}, 32'd3, 4'hF, 1, 1, 0, 1'b0);
      axi_write({REG_AUX,  2'b00}, 32'd4, 4'hF, 0, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

      // W well ahead of AW, then AW ahead of W
      axi_write(4'h0, 32'h1234_5678, 4'hF, 3, 0, 0, 1'b0);
      axi_write(4'hC, 32'h0BAD_F00D, 4'hF, 0, 2, 0, 1'b0);

      // Byte strobes, including an all-zero strobe and an unaligned address
      axi_write(4'h4, 32'hAABB_CCDD, 4'hF, 0, 0, 0, 1'b0);
      axi_write(4'h4, 32'h1122_3344, 4'b0101, 0, 0, 0, 1'b0);
      chk("strb_merge_reg1", reg_q[1], 32'hAA22_CC44);
      axi_write(4'h6, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 1'b0);
      axi_read(4'h5, 0);

      // Back-pressure on B (with a second AW waiting) and on R
      axi_write(4'h8, 32'h0000_0003, 4'hF, 0, 0, 5, 1'b1);
      chk("stalled_aw_ignored", reg_q[0], mdl[0]);
      axi_read(4'h9, 5);

      // Read and write commit hit register 2 in the same cycle
      chk("pre_awready", 32'(axi.S_AXI_AWREADY), 1);
      chk("pre_arready", 32'(axi.S_AXI_ARREADY), 1);
      axi.S_AXI_AWADDR = 4'h8; axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
      axi.S_AXI_ARADDR = 4'h8; axi.S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
      chk("rw_same_rdata", axi.S_AXI_RDATA, 32'd3);
      chk("rw_same_rvalid", 32'(axi.S_AXI_RVALID), 1);
      chk("rw_same_bvalid", 32'(axi.S_AXI_BVALID), 1);
      mdl_write(2, 32'h55, 4'hF);
      chk("rw_same_reg", reg_q[2], mdl[2]);
      axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
      chk("rw_same_bdrop", 32'(axi.S_AXI_BVALID), 0);
      chk("rw_same_rdrop", 32'(axi.S_AXI_RVALID), 0);
      axi_read(4'h8, 0);

      // Reset while a B response is outstanding
      axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WDATA = 32'hDEAD_BEEF; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
      chk("pend_bvalid", 32'(axi.S_AXI_BVALID), 1);
      #2 ARESETN = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      chk("midrst_bvalid", 32'(axi.S_AXI_BVALID), 0);
      chk("midrst_pulse", 32'(reg_wr_pulse), 0);
      chk_all_regs("midrst_reg");
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      axi_write(4'h4, 32'hCAFE_0001, 4'hF, 0, 0, 0, 1'b0);
      axi_read(4'h4, 0);

      // Randomized traffic against the register model
      for (int n = 0; n < 80; n++) begin
         logic [3:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         a = 4'($urandom_range(0, 15));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0)
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
         else
            axi_read(a, $urandom_range(0, 3));
      end
      chk_all_regs("final_reg");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
